// File: rtl/risc8_pkg.sv
// Shared definitions for the risc8 core and its instruction-fetch/loader stage.
// The instruction format is op[7:6] with a 4-bit jump target in [3:0].
package risc8_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_ADDI = 2'b01;
  localparam logic [1:0] OP_BEQ  = 2'b10;
  localparam logic [1:0] OP_JUMP = 2'b11;

  localparam int IMEM_DEPTH = 16;

  // JUMP 15. Address 15 is never loaded, so it sits beyond any program and the core parks there.
  localparam logic [7:0] HALT_INSTR = {OP_JUMP, 2'b00, 4'hF};

  typedef enum logic {
    FETCH_LOAD = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/imem_fetch_if.sv
// Valid/ready byte stream carrying a program image into the fetch stage.
interface imem_fetch_if;

  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;

  modport master (output load_valid, output load_data, output load_last, input load_ready);
  modport slave  (input load_valid, input load_data, input load_last, output load_ready);

endinterface

// File: rtl/imem_ram.sv
// Instruction memory: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; prog_len gates what the core can see.
module imem_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_fetch.sv
// Program loader and instruction fetch for the risc8 core: holds the core in reset
// while a program streams in, then serves instructions and detects when it runs off the end.
module imem_fetch
  import risc8_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  imem_fetch_if.slave      load,
  input  logic             restart,
  input  logic [7:0]       pc,
  output logic [7:0]       instruction,
  output logic             cpu_reset,
  output logic             running,
  output logic             halted,
  output logic             load_err,
  output logic [3:0]       prog_len,
  output logic [CNT_W-1:0] run_cycles
);

  // The top entry is reserved as the halt landing spot, so loading stops one short.
  localparam logic [3:0] LAST_IDX = 4'(DEPTH - 2);

  fetch_state_e     state_q, state_d;
  logic [3:0]       wr_ptr_q, wr_ptr_d;
  logic [3:0]       prog_len_q, prog_len_d;
  logic             halted_q, halted_d;
  logic             load_err_q, load_err_d;
  logic [CNT_W-1:0] run_cycles_q, run_cycles_d;
  logic             mem_we;
  logic             in_range;
  logic [7:0]       mem_rdata;

  imem_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (load.load_data),
    .raddr_i (pc[3:0]),
    .rdata_o (mem_rdata)
  );

  assign in_range    = (pc < {4'h0, prog_len_q});
  assign instruction = in_range ? mem_rdata : HALT_INSTR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH_LOAD;
      wr_ptr_q     <= '0;
      prog_len_q   <= '0;
      halted_q     <= 1'b0;
      load_err_q   <= 1'b0;
      run_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      prog_len_q   <= prog_len_d;
      halted_q     <= halted_d;
      load_err_q   <= load_err_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  // restart wins over a same-cycle beat, which is dropped rather than written.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    prog_len_d   = prog_len_q;
    halted_d     = halted_q;
    load_err_d   = load_err_q;
    run_cycles_d = run_cycles_q;
    mem_we       = 1'b0;
    if (restart) begin
      state_d      = FETCH_LOAD;
      wr_ptr_d     = '0;
      prog_len_d   = '0;
      halted_d     = 1'b0;
      load_err_d   = 1'b0;
      run_cycles_d = '0;
    end else begin
      case (state_q)
        FETCH_LOAD: begin
          if (load.load_valid) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 4'd1;
            if (load.load_last || (wr_ptr_q == LAST_IDX)) begin
              state_d    = FETCH_RUN;
              prog_len_d = wr_ptr_q + 4'd1;
              load_err_d = ~load.load_last;
            end
          end
        end
        FETCH_RUN: begin
          if (!in_range) begin
            halted_d = 1'b1;
          end
          if (!halted_q && (run_cycles_q != '1)) begin
            run_cycles_d = run_cycles_q + CNT_W'(1);
          end
        end
        default: state_d = FETCH_LOAD;
      endcase
    end
  end

  assign load.load_ready = (state_q == FETCH_LOAD);
  assign cpu_reset       = (state_q == FETCH_LOAD);
  assign running         = (state_q == FETCH_RUN);
  assign halted          = halted_q;
  assign load_err        = load_err_q;
  assign prog_len        = prog_len_q;
  assign run_cycles      = run_cycles_q;

endmodule

// File: doc/imem_fetch.md
# imem_fetch

Instruction-memory and program-loader stage sitting directly upstream of `cpu`. It accepts a program over a valid/ready byte stream, stores it in a 16-entry instruction memory, and holds the core in reset while loading. It then releases the core and drives `instruction` combinationally from the core's `pc`. Any fetch beyond the loaded program returns a self-looping halt instruction, so the core parks cleanly.

## Interface
- `DEPTH`, 16: instruction memory entries; fixed by the 4-bit jump target.
- `CNT_W`, 16: width of `run_cycles`.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: reset is asynchronous and active-high.
- `load_valid` in 1: load beat valid.
- `load_data` in 8: instruction byte for the current beat.
- `load_last` in 1: marks the final beat of the program.
- `load_ready` out 1: beat accepted when `load_valid && load_ready`.
- `restart` in 1: one-cycle pulse; return to loading.
- `pc` in 8: core program counter.
- `instruction` out 8: instruction for `pc`, to core `instruction`.
- `cpu_reset` out 1: drives core `reset`.
- `running` out 1: state is RUN.
- `halted` out 1: sticky; core has fetched past program end.
- `load_err` out 1: sticky; program truncated at 15 words.
- `prog_len` out 4: number of loaded words (0..15).
- `run_cycles` out CNT_W: cycles spent in RUN before halt, saturating.

## Operation
- States: LOAD, RUN. Reset and `restart` both enter LOAD.
- **LOAD**
  - `load_ready`=1 and `cpu_reset`=1.
  - Each accepted beat writes `mem[wr_ptr]` and increments `wr_ptr`.
  - An accepted beat with `load_last`=1 moves to RUN, with `prog_len` = `wr_ptr`+1.
  - A beat accepted at `wr_ptr`=14 without `load_last` is treated as last. `load_err` is set and `prog_len`=15.
  - Entry 15 is never written, so it is always beyond the program.
- **RUN**
  - `load_ready`=0, `cpu_reset`=0, `running`=1.
  - Beats are ignored; `mem` is frozen.
- **Fetch (combinational, any state)**
  - If `pc` < `prog_len`: `instruction` = `mem[pc[3:0]]`.
  - Otherwise: `instruction` = 8'hCF (JUMP 15). Address 15 is itself ≥ `prog_len`, so the core self-loops with no register writes.
- **`halted`**: set on any RUN edge where `pc` ≥ `prog_len`. Cleared only by reset or `restart`.
- **`run_cycles`**: increments each RUN edge while `halted`=0; saturates at all-ones.
- **`restart`**
  - Takes priority over any same-cycle beat, which is not written.
  - Clears `wr_ptr`, `prog_len`, `halted`, `load_err`, `run_cycles`.
  - Asserts `cpu_reset` from the next edge.
- **Reset values**
  - State LOAD, `wr_ptr`=0, `prog_len`=0, `cpu_reset`=1, `load_ready`=1, `running`=0, `halted`=0, `load_err`=0, `run_cycles`=0.
  - `mem` contents are not reset. `prog_len`=0 makes every fetch return 8'hCF.
- Reset mid-load or mid-run aborts immediately. A partially loaded program is discarded by virtue of `prog_len`=0.

## Timing
- `load_ready`, `cpu_reset`, `running`, `halted`, `load_err`, `prog_len`, `run_cycles` are registered outputs.
- `cpu_reset` falls on the same edge that accepts the last beat.
- The core's `pc`=0 instruction executes on the following edge.
- Fetch latency is zero: `instruction` follows `pc` combinationally, as the core requires.
- `halted` rises on the edge after the core's `pc` first goes ≥ `prog_len`. That is the edge on which `pc` is sampled out of range.
- `restart` is sampled on an edge. `cpu_reset` and `load_ready` are high after that edge, and the core `pc` returns to 0 asynchronously.

## Structure
- Shared package `risc8_pkg`:
  - opcode constants (ADD, ADDI, BEQ, JUMP);
  - `HALT_INSTR` = 8'hCF;
  - `IMEM_DEPTH` = 16;
  - fetch state enum.
- One natural sub-module, `imem_ram`: 16×8 memory with one synchronous write port and one asynchronous read port.
- The FSM, counters and halt mux live in `imem_fetch`.

## Test plan
- **Sum program.** Load the 10-word sum program, `load_last` on word 9.
  - During load: `prog_len`=10 at completion, `cpu_reset` falls on that edge.
  - After the loop: the core's r2=45 and `halted`=1.
  - Afterwards: `instruction` reads 8'hCF and the core `pc` holds at 15.
- **Backpressure gaps.** Insert `load_valid`=0 gaps between beats → no writes during gaps; final `prog_len` and memory contents are identical to the gap-free load.
- **Overflow.** Stream 16 beats with no `load_last`.
  - Beat 15 (index 14) ends the load with `load_err`=1 and `prog_len`=15.
  - Beat 16 is not accepted (`load_ready`=0 in RUN).
- **Empty program.** Reset, then a single beat with `load_last`=1 and data 8'hCF → `prog_len`=1. `halted` rises in the first or second RUN cycle, and `run_cycles` stops at 1 or 2.
- **Restart mid-run.**
  - Pulse `restart` → `cpu_reset`=1 and `halted`=0 next cycle; a same-cycle beat is dropped.
  - A reload of 4 words gives `prog_len`=4.
  - `pc`=5 fetches 8'hCF.
- **Async reset mid-load.** Assert `reset` asynchronously mid-load → all outputs take their reset values without waiting for an edge. The subsequent 3-word load starts at index 0.
